// File: rtl/cap_pkg.sv
// Shared definitions for the capture frame scheduler and the capture VRAM writer:
// FSM encoding, burst geometry and buffer-rotation helper.
package cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } cap_state_e;

  localparam int BYTE_PER_BURST = 256;

  // One burst carries 64 pixels of 4 bytes, so a frame is width*height/64 bursts.
  localparam logic [13:0] BURSTS_640x480   = 14'd4800;
  localparam logic [13:0] BURSTS_800x600   = 14'd7500;
  localparam logic [13:0] BURSTS_1024x768  = 14'd12288;

  function automatic logic [13:0] burst_target(input logic [1:0] resol);
    logic [13:0] tgt;
    case (resol)
      2'd1:    tgt = BURSTS_800x600;
      2'd2:    tgt = BURSTS_1024x768;
      default: tgt = BURSTS_640x480;
    endcase
    return tgt;
  endfunction

  // With three buffers the one being scanned out is skipped so it is never overwritten.
  function automatic logic [1:0] next_buf(input logic [1:0] cur,
                                          input logic [1:0] bufnum,
                                          input logic [1:0] disp);
    logic [1:0] n;
    if (bufnum == 2'd0 || bufnum == 2'd1) begin
      n = 2'd0;
    end else if (bufnum == 2'd2) begin
      n = (cur == 2'd0) ? 2'd1 : 2'd0;
    end else begin
      n = (cur >= 2'd2) ? 2'd0 : cur + 2'd1;
      if (n == disp) n = (n == 2'd2) ? 2'd0 : n + 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/cap_vsync_det.sv
// Three-flop VSYNC synchroniser with rising-edge detect; shared with the capture
// writer so both see the frame start on the same ACLK edge.
module cap_vsync_det (
  input  logic ACLK,
  input  logic ARST,
  input  logic VSYNC,
  output logic vsync_rise
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], VSYNC};
  end

  always_ff @(posedge ACLK) begin
    if (ARST) sync_q <= 3'b000;
    else      sync_q <= sync_d;
  end

  assign vsync_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/cap_frame_sched.sv
// Capture frame scheduler: arms on VSYNC, counts write-response bursts per frame
// and rotates through up to three frame buffers.
module cap_frame_sched
  import cap_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        VSYNC,
  input  logic [1:0]  RESOL,
  input  logic        CAPSTART,
  input  logic        CAPSTOP,
  input  logic        CAPMODE,
  input  logic [1:0]  BUFNUM,
  input  logic [28:0] BUFBASE0,
  input  logic [28:0] BUFBASE1,
  input  logic [28:0] BUFBASE2,
  input  logic [1:0]  DISPBUF,
  input  logic        BVALID,
  input  logic        BREADY,
  input  logic [1:0]  BRESP,
  output logic        CAPON,
  output logic [28:0] CAPADDR,
  output logic [1:0]  CURBUF,
  output logic [1:0]  LASTBUF,
  output logic        FRAME_DONE,
  output logic        BUSY,
  output logic        ERR_BRESP,
  output logic        ERR_SHORT,
  output logic [15:0] FRMCNT
);

  cap_state_e  state_q, state_d;
  logic [28:0] capaddr_q, capaddr_d;
  logic [1:0]  curbuf_q, curbuf_d;
  logic [1:0]  lastbuf_q, lastbuf_d;
  logic [15:0] frmcnt_q, frmcnt_d;
  logic        err_bresp_q, err_bresp_d;
  logic        err_short_q, err_short_d;
  logic        stop_req_q, stop_req_d;
  logic [13:0] burst_cnt_q, burst_cnt_d;
  logic [13:0] target_q, target_d;

  logic        vsync_rise;
  logic        b_acc;
  logic [1:0]  next_idx;
  logic [28:0] next_base;

  cap_vsync_det u_vsync_det (
    .ACLK       (ACLK),
    .ARST       (ARST),
    .VSYNC      (VSYNC),
    .vsync_rise (vsync_rise)
  );

  assign b_acc    = BVALID & BREADY;
  assign next_idx = next_buf(curbuf_q, BUFNUM, DISPBUF);

  always_comb begin
    case (next_idx)
      2'd0:    next_base = BUFBASE0;
      2'd1:    next_base = BUFBASE1;
      default: next_base = BUFBASE2;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    capaddr_d   = capaddr_q;
    curbuf_d    = curbuf_q;
    lastbuf_d   = lastbuf_q;
    frmcnt_d    = frmcnt_q;
    err_bresp_d = err_bresp_q;
    err_short_d = err_short_q;
    stop_req_d  = stop_req_q;
    burst_cnt_d = burst_cnt_q;
    target_d    = target_q;

    if (CAPSTOP && state_q != ST_IDLE) stop_req_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (CAPSTART) begin
          state_d     = ST_ARM;
          curbuf_d    = 2'd0;
          capaddr_d   = BUFBASE0;
          err_bresp_d = 1'b0;
          err_short_d = 1'b0;
          stop_req_d  = CAPSTOP;
          burst_cnt_d = 14'd0;
          target_d    = burst_target(RESOL);
        end
      end
      ST_ARM: begin
        burst_cnt_d = 14'd0;
        if (vsync_rise) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        // A completing burst wins over a coincident VSYNC edge.
        if (b_acc && BRESP != 2'b00) err_bresp_d = 1'b1;
        if (b_acc && burst_cnt_q == target_q - 14'd1) begin
          state_d     = ST_DONE;
          burst_cnt_d = 14'd0;
        end else if (vsync_rise) begin
          err_short_d = 1'b1;
          burst_cnt_d = 14'd0;
        end else if (b_acc) begin
          burst_cnt_d = burst_cnt_q + 14'd1;
        end
      end
      ST_DONE: begin
        lastbuf_d = curbuf_q;
        frmcnt_d  = frmcnt_q + 16'd1;
        curbuf_d  = next_idx;
        capaddr_d = next_base;
        target_d  = burst_target(RESOL);
        if (CAPMODE && !stop_req_q && !CAPSTOP) begin
          state_d = ST_ARM;
        end else begin
          state_d    = ST_IDLE;
          stop_req_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q     <= ST_IDLE;
      capaddr_q   <= 29'd0;
      curbuf_q    <= 2'd0;
      lastbuf_q   <= 2'd0;
      frmcnt_q    <= 16'd0;
      err_bresp_q <= 1'b0;
      err_short_q <= 1'b0;
      stop_req_q  <= 1'b0;
      burst_cnt_q <= 14'd0;
      target_q    <= 14'd0;
    end else begin
      state_q     <= state_d;
      capaddr_q   <= capaddr_d;
      curbuf_q    <= curbuf_d;
      lastbuf_q   <= lastbuf_d;
      frmcnt_q    <= frmcnt_d;
      err_bresp_q <= err_bresp_d;
      err_short_q <= err_short_d;
      stop_req_q  <= stop_req_d;
      burst_cnt_q <= burst_cnt_d;
      target_q    <= target_d;
    end
  end

  assign CAPON      = (state_q == ST_CAPT);
  assign FRAME_DONE = (state_q == ST_DONE);
  assign BUSY       = (state_q != ST_IDLE);
  assign CAPADDR    = capaddr_q;
  assign CURBUF     = curbuf_q;
  assign LASTBUF    = lastbuf_q;
  assign FRMCNT     = frmcnt_q;
  assign ERR_BRESP  = err_bresp_q;
  assign ERR_SHORT  = err_short_q;

endmodule

// File: tb/tb_cap_frame_sched.sv
// Scoreboard bench for cap_frame_sched: frame-completion expectations are queued by
// the stimulus and checked by a monitor when FRAME_DONE is seen.
module tb_cap_frame_sched;

  logic        ACLK;
  logic        ARST;
  logic        VSYNC;
  logic [1:0]  RESOL;
  logic        CAPSTART;
  logic        CAPSTOP;
  logic        CAPMODE;
  logic [1:0]  BUFNUM;
  logic [28:0] BUFBASE0;
  logic [28:0] BUFBASE1;
  logic [28:0] BUFBASE2;
  logic [1:0]  DISPBUF;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic        CAPON;
  logic [28:0] CAPADDR;
  logic [1:0]  CURBUF;
  logic [1:0]  LASTBUF;
  logic        FRAME_DONE;
  logic        BUSY;
  logic        ERR_BRESP;
  logic        ERR_SHORT;
  logic [15:0] FRMCNT;

  localparam logic [28:0] BASE0 = 29'h0100_0000;
  localparam logic [28:0] BASE1 = 29'h0200_4000;
  localparam logic [28:0] BASE2 = 29'h0300_8000;

  typedef struct {
    logic [1:0]  lastbuf;
    logic [15:0] frmcnt;
    logic [1:0]  curbuf;
    logic [28:0] capaddr;
    logic        busy;
  } frame_exp_t;

  frame_exp_t expQ[$];
  int checks = 0;
  int errors = 0;
  bit framePending = 0;

  cap_frame_sched dut (
    .ACLK       (ACLK),
    .ARST       (ARST),
    .VSYNC      (VSYNC),
    .RESOL      (RESOL),
    .CAPSTART   (CAPSTART),
    .CAPSTOP    (CAPSTOP),
    .CAPMODE    (CAPMODE),
    .BUFNUM     (BUFNUM),
    .BUFBASE0   (BUFBASE0),
    .BUFBASE1   (BUFBASE1),
    .BUFBASE2   (BUFBASE2),
    .DISPBUF    (DISPBUF),
    .BVALID     (BVALID),
    .BREADY     (BREADY),
    .BRESP      (BRESP),
    .CAPON      (CAPON),
    .CAPADDR    (CAPADDR),
    .CURBUF     (CURBUF),
    .LASTBUF    (LASTBUF),
    .FRAME_DONE (FRAME_DONE),
    .BUSY       (BUSY),
    .ERR_BRESP  (ERR_BRESP),
    .ERR_SHORT  (ERR_SHORT),
    .FRMCNT     (FRMCNT)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic pushFrame(input logic [1:0] lb, input logic [15:0] fc,
                           input logic [1:0] cb, input logic [28:0] ca, input logic bz);
    frame_exp_t e;
    e.lastbuf = lb;
    e.frmcnt  = fc;
    e.curbuf  = cb;
    e.capaddr = ca;
    e.busy    = bz;
    expQ.push_back(e);
  endtask

  // Frame results settle in the cycle after the FRAME_DONE pulse.
  always @(negedge ACLK) begin
    frame_exp_t e;
    if (framePending) begin
      framePending = 0;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedFrame", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("frameLastbuf", 32'(LASTBUF), 32'(e.lastbuf));
        checkOutput("frameFrmcnt",  32'(FRMCNT),  32'(e.frmcnt));
        checkOutput("frameCurbuf",  32'(CURBUF),  32'(e.curbuf));
        checkOutput("frameCapaddr", 32'(CAPADDR), 32'(e.capaddr));
        checkOutput("frameBusy",    32'(BUSY),    32'(e.busy));
      end
    end
    if (FRAME_DONE) framePending = 1;
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_capon"},     32'(CAPON),      32'd0);
    checkOutput({tag, "_capaddr"},   32'(CAPADDR),    32'd0);
    checkOutput({tag, "_curbuf"},    32'(CURBUF),     32'd0);
    checkOutput({tag, "_lastbuf"},   32'(LASTBUF),    32'd0);
    checkOutput({tag, "_framedone"}, 32'(FRAME_DONE), 32'd0);
    checkOutput({tag, "_busy"},      32'(BUSY),       32'd0);
    checkOutput({tag, "_errbresp"},  32'(ERR_BRESP),  32'd0);
    checkOutput({tag, "_errshort"},  32'(ERR_SHORT),  32'd0);
    checkOutput({tag, "_frmcnt"},    32'(FRMCNT),     32'd0);
  endtask

  task automatic pulseVsync();
    VSYNC = 1'b1;
    repeat (6) tick();
    VSYNC = 1'b0;
    repeat (2) tick();
  endtask

  task automatic startCapture();
    CAPSTART = 1'b1;
    tick();
    CAPSTART = 1'b0;
    checkOutput("armBusy",    32'(BUSY),    32'd1);
    checkOutput("armCapon",   32'(CAPON),   32'd0);
    checkOutput("armCurbuf",  32'(CURBUF),  32'd0);
    checkOutput("armCapaddr", 32'(CAPADDR), 32'(BASE0));
  endtask

  task automatic pulseStop();
    CAPSTOP = 1'b1;
    tick();
    CAPSTOP = 1'b0;
  endtask

  task automatic sendBursts(input int n, input int errIdx);
    for (int i = 0; i < n; i++) begin
      BVALID = 1'b1;
      BREADY = 1'b1;
      BRESP  = (i == errIdx) ? 2'd2 : 2'd0;
      tick();
    end
    BVALID = 1'b0;
    BRESP  = 2'd0;
  endtask

  // Holds back the final burst so a premature completion shows up as CAPON low.
  task automatic finishFrame(input int n, input int errIdx);
    sendBursts(n - 1, errIdx);
    checkOutput("caponBeforeLast", 32'(CAPON), 32'd1);
    sendBursts(1, -1);
    repeat (3) tick();
  endtask

  task automatic applyStimulus();
    // Single frame, one buffer.
    RESOL = 2'd0; CAPMODE = 1'b0; BUFNUM = 2'd1; DISPBUF = 2'd0;
    startCapture();
    pulseVsync();
    checkOutput("captCapon", 32'(CAPON), 32'd1);
    pushFrame(2'd0, 16'd1, 2'd0, BASE0, 1'b0);
    finishFrame(4800, -1);
    checkOutput("singleIdleCapon", 32'(CAPON), 32'd0);
    checkOutput("singleIdleBusy",  32'(BUSY),  32'd0);

    // Responses while idle must not raise the error flag.
    sendBursts(5, 0);
    checkOutput("idleBrespIgnored", 32'(ERR_BRESP), 32'd0);

    // Triple buffering with buffer 1 on display, continuous.
    BUFNUM = 2'd3; DISPBUF = 2'd1; CAPMODE = 1'b1;
    startCapture();
    pulseVsync();
    pushFrame(2'd0, 16'd2, 2'd2, BASE2, 1'b1);
    finishFrame(4800, -1);
    checkOutput("tripleArmCurbuf", 32'(CURBUF), 32'd2);
    pulseVsync();
    pushFrame(2'd2, 16'd3, 2'd0, BASE0, 1'b1);
    sendBursts(50, -1);
    CAPSTART = 1'b1;
    tick();
    CAPSTART = 1'b0;
    finishFrame(4750, -1);
    pulseStop();
    pulseVsync();
    checkOutput("tripleThirdCurbuf",  32'(CURBUF),  32'd0);
    checkOutput("tripleThirdCapaddr", 32'(CAPADDR), 32'(BASE0));
    pushFrame(2'd0, 16'd4, 2'd2, BASE2, 1'b0);
    finishFrame(4800, -1);
    checkOutput("tripleStoppedBusy", 32'(BUSY), 32'd0);

    // Short frame: second VSYNC after 100 bursts, two buffers.
    BUFNUM = 2'd2; CAPMODE = 1'b0;
    startCapture();
    pulseVsync();
    sendBursts(100, -1);
    pulseVsync();
    checkOutput("shortErr",    32'(ERR_SHORT), 32'd1);
    checkOutput("shortCurbuf", 32'(CURBUF),    32'd0);
    checkOutput("shortCapon",  32'(CAPON),     32'd1);
    pushFrame(2'd0, 16'd5, 2'd1, BASE1, 1'b0);
    finishFrame(4800, -1);

    // Stop request mid-frame in continuous mode.
    BUFNUM = 2'd1; CAPMODE = 1'b1;
    startCapture();
    checkOutput("errShortCleared", 32'(ERR_SHORT), 32'd0);
    pulseVsync();
    sendBursts(10, -1);
    pulseStop();
    checkOutput("stopStillCapturing", 32'(CAPON), 32'd1);
    pushFrame(2'd0, 16'd6, 2'd0, BASE0, 1'b0);
    finishFrame(4790, -1);
    checkOutput("stopIdle", 32'(BUSY), 32'd0);

    // Error response on burst 5, then reset mid-frame.
    BUFNUM = 2'd3; DISPBUF = 2'd0; CAPMODE = 1'b0;
    startCapture();
    pulseVsync();
    pushFrame(2'd0, 16'd7, 2'd1, BASE1, 1'b0);
    finishFrame(4800, 4);
    checkOutput("brespSticky", 32'(ERR_BRESP), 32'd1);
    startCapture();
    checkOutput("brespCleared", 32'(ERR_BRESP), 32'd0);
    pulseVsync();
    sendBursts(2000, -1);
    ARST = 1'b1;
    tick();
    checkResetState("midReset");
    ARST = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    ARST = 1'b1; VSYNC = 1'b0; RESOL = 2'd0; CAPSTART = 1'b0; CAPSTOP = 1'b0;
    CAPMODE = 1'b0; BUFNUM = 2'd1; BUFBASE0 = BASE0; BUFBASE1 = BASE1;
    BUFBASE2 = BASE2; DISPBUF = 2'd0; BVALID = 1'b0; BREADY = 1'b0; BRESP = 2'd0;
    repeat (3) tick();
    checkResetState("reset");
    ARST = 1'b0;
    tick();
    applyStimulus();
    for (int i = 0; i < 20 && expQ.size() != 0; i++) tick();
    checkOutput("pendingFrames", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cap_frame_sched.md
CAP_FRAME_SCHED -- requirements
Module: cap_frame_sched

Interface
REQ-001 SHALL have port ACLK  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have port ARST  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port VSYNC  in  1  camera frame sync, asynchronous to ACLK, active-high.
REQ-004 SHALL have port RESOL  in  2  frame size: 0=640x480, 1=800x600, 2=1024x768, 3=treated as 0.
REQ-005 SHALL have port CAPSTART  in  1  one-cycle start pulse from register block.
REQ-006 SHALL have port CAPSTOP  in  1  one-cycle stop request pulse.
REQ-007 SHALL have port CAPMODE  in  1  0=single frame, 1=continuous.
REQ-008 SHALL have port BUFNUM  in  2  number of frame buffers, 1..3; 0 treated as 1.
REQ-009 SHALL have ports BUFBASE0/1/2  in  29 each  byte base address of buffers 0..2.
REQ-010 SHALL have port DISPBUF  in  2  index of buffer currently scanned out by display.
REQ-011 SHALL have ports BVALID in 1, BREADY in 1, BRESP in 2  monitored copy of the capture writer's AXI B channel.
REQ-012 SHALL have port CAPON  out  1  enables the capture VRAM writer.
REQ-013 SHALL have port CAPADDR  out  29  base address of the buffer being written.
REQ-014 SHALL have port CURBUF  out  2  index of buffer being written.
REQ-015 SHALL have port LASTBUF  out  2  index of most recently completed buffer.
REQ-016 SHALL have port FRAME_DONE  out  1  one-cycle pulse per completed frame.
REQ-017 SHALL have ports BUSY out 1, ERR_BRESP out 1, ERR_SHORT out 1, FRMCNT out 16.

Function
REQ-018 SHALL synchronise VSYNC through 3 flops; vsync_rise = stage2 AND NOT stage3 (same edge timing as the capture writer).
REQ-019 SHALL count B accepts (BVALID AND BREADY) per frame in a 14-bit counter; target bursts = 4800 / 7500 / 12288 for RESOL 0 / 1 / 2 (256 bytes per burst, 4 bytes per pixel).
REQ-020 SHALL implement FSM states IDLE, ARM, CAPT, DONE.
REQ-021 IDLE: CAPSTART -> ARM, CURBUF=0, CAPADDR=BUFBASE0, clear ERR_BRESP/ERR_SHORT, clear stop_req.
REQ-022 ARM: wait for vsync_rise -> CAPT; clear burst counter; CAPADDR stays constant throughout ARM.
REQ-023 CAPT: CAPON=1; when burst counter reaches target-1 and a B accept occurs -> DONE.
REQ-024 CAPT: vsync_rise before target reached -> set ERR_SHORT, clear counter, stay CAPT at the same buffer.
REQ-025 DONE (1 cycle): CAPON=0, FRAME_DONE=1, LASTBUF<=CURBUF, FRMCNT+1 (wraps at 0xFFFF->0); next state ARM if CAPMODE=1 and no stop_req, else IDLE.
REQ-026 Next buffer on DONE: n=(CURBUF+1) mod BUFNUM; if BUFNUM=3 and n=DISPBUF then n=(n+1) mod 3; CAPADDR<=BUFBASEn in the same cycle.
REQ-027 BUFNUM=1: CURBUF always 0; BUFNUM=2: strict alternation without DISPBUF check.
REQ-028 CAPSTOP in any non-IDLE state sets stop_req; the capture ends at the next DONE; a frame is never cut mid-way.
REQ-029 CAPSTART while not IDLE SHALL be ignored; simultaneous CAPSTART and CAPSTOP in IDLE: start wins, stop_req set.
REQ-030 Any B accept with BRESP!=0 SHALL set sticky ERR_BRESP; the burst is still counted.
REQ-031 B accepts outside CAPT SHALL be ignored.
REQ-032 BUSY = (state != IDLE).
REQ-033 BUFBASE/BUFNUM/RESOL changes take effect only at IDLE->ARM or DONE.

Reset
REQ-034 ARST SHALL force state IDLE; CAPON=0, CAPADDR=0, CURBUF=0, LASTBUF=0, FRAME_DONE=0, ERR_*=0, FRMCNT=0, counters=0, sync flops=0, stop_req=0.
REQ-035 ARST mid-frame SHALL drop CAPON in the following cycle, with no FRAME_DONE.

Structure
REQ-036 Shared package cap_pkg SHALL hold FSM state encoding, BYTE_PER_BURST=256 and the per-RESOL burst-count constants.
REQ-037 The VSYNC synchroniser/edge detector SHALL be sub-module cap_vsync_det, reusable by the writer.

Verification
REQ-038 Single: RESOL=0, CAPMODE=0, CAPSTART, VSYNC, 4800 B OK -> one FRAME_DONE, LASTBUF=0, FRMCNT=1, IDLE, CAPON=0.
REQ-039 Triple: BUFNUM=3, DISPBUF=1, continuous, 3 frames -> CURBUF sequence 0,2,0; CAPADDR tracks BUFBASE0/2/0.
REQ-040 Short frame: second vsync_rise after 100 bursts -> ERR_SHORT=1, CURBUF unchanged, counter restarts, next full frame completes.
REQ-041 Stop: CAPSTOP at burst 10 of continuous frame -> frame finishes at 4800, FRAME_DONE, then IDLE.
REQ-042 Error/reset: BRESP=2 on burst 5 -> ERR_BRESP=1, still 4800 needed; ARST at burst 2000 -> all outputs at reset values next cycle.
